// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - programmable repeating BCD digit stream source with valid/ready output
module sequence_generator #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] seq_in,
    input  logic [CNT_W-1:0]              repeat_count,
    output logic [DIGIT_W-1:0]            digit,
    output logic                          digit_valid,
    input  logic                          digit_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam int SEQ_W = NUM_DIGITS * DIGIT_W;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    // Index 0 selects the most significant digit, which is emitted first.
    function automatic logic [DIGIT_W-1:0] nibble(input logic [SEQ_W-1:0] s,
                                                  input logic [IDX_W-1:0] i);
        return s[(NUM_DIGITS - 1 - int'(i)) * DIGIT_W +: DIGIT_W];
    endfunction

    function automatic logic is_bcd(input logic [SEQ_W-1:0] s);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (s[k*DIGIT_W +: DIGIT_W] > DIGIT_W'(9)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        digit_d = digit_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_bcd(seq_in)) begin
                        seq_d   = seq_in;
                        rem_d   = (repeat_count == '0) ? CNT_W'(1) : repeat_count;
                        idx_d   = '0;
                        digit_d = nibble(seq_in, '0);
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        state_d = S_EMIT;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (valid_q && digit_ready) begin
                    if (idx_q != IDX_LAST) begin
                        idx_d   = idx_q + IDX_W'(1);
                        digit_d = nibble(seq_q, idx_q + IDX_W'(1));
                    end else if (rem_q > CNT_W'(1)) begin
                        rem_d = rem_q - CNT_W'(1);
                        idx_d = '0;
                        if (GAP_CYCLES > 0) begin
                            gap_d   = '0;
                            digit_d = '0;
                            valid_d = 1'b0;
                            state_d = S_GAP;
                        end else begin
                            digit_d = nibble(seq_q, '0);
                        end
                    end else begin
                        rem_d   = '0;
                        idx_d   = '0;
                        digit_d = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    digit_d = nibble(seq_q, idx_q);
                    valid_d = 1'b1;
                    state_d = S_EMIT;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            seq_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            digit_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule
